// File: rtl/ov5640_cfg_pkg.sv
// ---------------------------------------------------------------------------
// ov5640_cfg_pkg
//
// Shared definitions for the OV5640 configuration sequencer:
//   - sequencer state enum (READ exists only with OV5640_CFG_READBACK_EN)
//   - device-address codes that mark a table hole and the end-of-table sentinel
//   - bit positions of the fields inside a 32-bit table entry
//     {dev_addr[31:24], reg_addr[23:8], reg_data[7:0]}
//   - small helpers for field extraction and delay-counter presets
// ---------------------------------------------------------------------------
package ov5640_cfg_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        PWR_WAIT = 4'd1,
        FETCH    = 4'd2,
        REQ      = 4'd3,
        SETTLE   = 4'd4,
        GAP      = 4'd5,
        DONE     = 4'd6,
        ERROR    = 4'd7
`ifdef OV5640_CFG_READBACK_EN
        ,
        READ     = 4'd8
`endif
    } state_t;

    localparam logic [7:0] SENTINEL_DEV = 8'hFF;
    localparam logic [7:0] HOLE_DEV     = 8'h00;

    localparam int DEV_LSB  = 24;
    localparam int DEV_W    = 8;
    localparam int REG_LSB  = 8;
    localparam int REG_W    = 16;
    localparam int DATA_LSB = 0;
    localparam int DATA_W   = 8;

    function automatic logic [7:0] entry_dev(input logic [31:0] entry);
        return entry[DEV_LSB +: DEV_W];
    endfunction

    function automatic logic [15:0] entry_reg(input logic [31:0] entry);
        return entry[REG_LSB +: REG_W];
    endfunction

    function automatic logic [7:0] entry_data(input logic [31:0] entry);
        return entry[DATA_LSB +: DATA_W];
    endfunction

    // The delay counter is loaded on the cycle that enters a wait state and
    // that state exits on the cycle it sees zero, so a preset of N-1 gives a
    // dwell of exactly N cycles (a request for 0 still dwells one cycle).
    function automatic logic [19:0] dly_preset(input logic [19:0] cycles);
        return (cycles == 20'd0) ? 20'd0 : cycles - 20'd1;
    endfunction

endpackage

// File: rtl/cfg_delay_cnt.sv
// ---------------------------------------------------------------------------
// cfg_delay_cnt
//
// Loadable down-counter with a zero flag. The sequencer reuses one instance
// for the power-up wait, the post-soft-reset settle and the inter-write gap.
// The count stops at zero instead of wrapping.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   load       in   load load_value this cycle (takes priority over counting)
//   load_value in   WIDTH-bit preset
//   zero       out  count has reached zero
// ---------------------------------------------------------------------------
module cfg_delay_cnt #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ov5640_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// ov5640_cfg_sequencer
//
// Walks the OV5640 register table and issues one SCCB/I2C write per entry to
// a downstream write master (level request, one-cycle done/nack response).
// Skips holes (dev 0x00), stops at the sentinel (dev 0xFF), retries NACKed
// writes up to MAX_RETRY times, and inserts a settle delay after the write at
// index 0 (the sensor soft reset).
//
// Optional feature, macro OV5640_CFG_READBACK_EN: after each successful write
// (except index 0) the same address is read back with i2c_rd=1; a differing
// value or a NACK increments the saturating mismatch_cnt.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_start         one-cycle pulse: (re)start from IDLE, DONE or ERROR
//   lut_index         table address driven to the LUT
//   lut_data          table entry returned combinationally for lut_index
//   i2c_req           write request, held until i2c_done
//   i2c_dev_addr      device address of the current transfer
//   i2c_reg_addr      register address of the current transfer
//   i2c_wr_data       register data of the current transfer
//   i2c_done          one-cycle completion pulse
//   i2c_nack          qualifies i2c_done; 1 = transfer failed
//   cfg_busy          sequence in progress
//   cfg_done          sticky, sentinel reached
//   cfg_error         sticky, retries exhausted or table overrun
//   i2c_rd            (readback only) current transfer is a read
//   i2c_rd_data       (readback only) data returned by a read
//   mismatch_cnt      (readback only) saturating readback mismatch count
// ---------------------------------------------------------------------------
module ov5640_cfg_sequencer
    import ov5640_cfg_pkg::*;
#(
    parameter logic [19:0] PWR_UP_CYCLES = 20'd1_000_000,
    parameter logic [19:0] SETTLE_CYCLES = 20'd250_000,
    parameter logic [15:0] GAP_CYCLES    = 16'd500,
    parameter int          MAX_RETRY     = 3,
    parameter logic [9:0]  LUT_DEPTH     = 10'd1023,
    parameter bit          AUTO_START    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    output logic [9:0]  lut_index,
    input  logic [31:0] lut_data,
    output logic        i2c_req,
    output logic [7:0]  i2c_dev_addr,
    output logic [15:0] i2c_reg_addr,
    output logic [7:0]  i2c_wr_data,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_error
`ifdef OV5640_CFG_READBACK_EN
    ,
    output logic        i2c_rd,
    input  logic [7:0]  i2c_rd_data,
    output logic [7:0]  mismatch_cnt
`endif
);

    state_t      state;
    state_t      state_next;
    logic [7:0]  retry_cnt;
    logic        advance;
    logic        start_seq;
    logic        dly_load;
    logic [19:0] dly_load_value;
    logic        dly_zero;
    logic [7:0]  lut_dev;
    logic        at_last_index;

    assign lut_dev       = entry_dev(lut_data);
    assign at_last_index = (lut_index >= LUT_DEPTH);

    cfg_delay_cnt #(
        .WIDTH(20)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (dly_load),
        .load_value(dly_load_value),
        .zero      (dly_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (AUTO_START || cfg_start) begin
                    state_next = PWR_WAIT;
                end
            end
            PWR_WAIT: begin
                if (dly_zero) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (lut_dev == SENTINEL_DEV) begin
                    state_next = DONE;
                end else if (lut_dev == HOLE_DEV) begin
                    // A hole at the last legal index would step past the table.
                    if (at_last_index) begin
                        state_next = ERROR;
                    end
                end else begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (i2c_done) begin
                    if (!i2c_nack) begin
`ifdef OV5640_CFG_READBACK_EN
                        state_next = (lut_index == 10'd0) ? SETTLE : READ;
`else
                        state_next = (lut_index == 10'd0) ? SETTLE : GAP;
`endif
                    end else if (retry_cnt < 8'(MAX_RETRY)) begin
                        state_next = GAP;
                    end else begin
                        state_next = ERROR;
                    end
                end
            end
`ifdef OV5640_CFG_READBACK_EN
            READ: begin
                if (i2c_done) begin
                    state_next = GAP;
                end
            end
`endif
            SETTLE: begin
                if (dly_zero) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (dly_zero) begin
                    state_next = (advance && at_last_index) ? ERROR : FETCH;
                end
            end
            DONE, ERROR: begin
                if (cfg_start) begin
                    state_next = PWR_WAIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        i2c_req  = (state == REQ);
        cfg_busy = (state == PWR_WAIT) || (state == FETCH) || (state == REQ) ||
                   (state == SETTLE) || (state == GAP);
`ifdef OV5640_CFG_READBACK_EN
        i2c_rd   = (state == READ);
        i2c_req  = i2c_req || (state == READ);
        cfg_busy = cfg_busy || (state == READ);
`endif
    end

    // The wait counter is preset on the transition into each wait state.
    assign start_seq = (state_next == PWR_WAIT) && (state != PWR_WAIT);
    assign dly_load  = (state_next != state) &&
                       ((state_next == PWR_WAIT) || (state_next == SETTLE) ||
                        (state_next == GAP));

    always_comb begin
        dly_load_value = 20'd0;
        case (state_next)
            PWR_WAIT: dly_load_value = dly_preset(PWR_UP_CYCLES);
            SETTLE:   dly_load_value = dly_preset(SETTLE_CYCLES);
            GAP:      dly_load_value = dly_preset({4'd0, GAP_CYCLES});
            default:  dly_load_value = 20'd0;
        endcase
    end

    // Index, transfer fields, retry bookkeeping and sticky status flags.
    // 'advance' remembers whether the last transfer succeeded, so the GAP exit
    // knows whether to move to the next index or re-issue the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_index    <= 10'd0;
            i2c_dev_addr <= 8'd0;
            i2c_reg_addr <= 16'd0;
            i2c_wr_data  <= 8'd0;
            retry_cnt    <= 8'd0;
            advance      <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_error    <= 1'b0;
        end else if (start_seq) begin
            lut_index <= 10'd0;
            retry_cnt <= 8'd0;
            advance   <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (lut_dev == HOLE_DEV) begin
                        if (!at_last_index) begin
                            lut_index <= lut_index + 10'd1;
                        end
                    end else if (lut_dev != SENTINEL_DEV) begin
                        i2c_dev_addr <= lut_dev;
                        i2c_reg_addr <= entry_reg(lut_data);
                        i2c_wr_data  <= entry_data(lut_data);
                    end
                end
                REQ: begin
                    if (i2c_done) begin
                        if (!i2c_nack) begin
                            retry_cnt <= 8'd0;
                            advance   <= 1'b1;
                        end else if (retry_cnt < 8'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + 8'd1;
                            advance   <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (dly_zero) begin
                        if (advance && !at_last_index) begin
                            lut_index <= lut_index + 10'd1;
                        end
                        advance <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (state_next == DONE) begin
                cfg_done <= 1'b1;
            end
            if (state_next == ERROR) begin
                cfg_error <= 1'b1;
            end
        end
    end

`ifdef OV5640_CFG_READBACK_EN
    // Readback mismatches (including a NACKed read) saturate at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt <= 8'd0;
        end else if ((state == READ) && i2c_done &&
                     (i2c_nack || (i2c_rd_data != i2c_wr_data)) &&
                     (mismatch_cnt != 8'hFF)) begin
            mismatch_cnt <= mismatch_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: doc/ov5640_cfg_sequencer.md
Name: ov5640_cfg_sequencer

Overview:
- Walks the OV5640 register look-up table by driving its 10-bit index and reading back the returned 32-bit entry {dev_addr[31:24], reg_addr[23:8], reg_data[7:0]}.
- Issues one SCCB/I2C write per entry to the downstream I2C write master, over a level request / pulse completion handshake.
- Sits between the power-up/reset logic and the I2C master, and reports when configuration is done or has failed.
- Also handles holes in the table, the end-of-table sentinel, NACK retries and the settle delay after a soft reset.

Parameters:
- PWR_UP_CYCLES, 20'd1_000_000: wait after start before the first write (20 ms at 50 MHz).
- SETTLE_CYCLES, 20'd250_000: extra wait after the write at index 0 (sensor soft reset).
- GAP_CYCLES, 16'd500: idle cycles between consecutive writes.
- MAX_RETRY, 3: NACK retries per entry before the block errors out.
- LUT_DEPTH, 10'd1023: last legal index; reaching it without a sentinel is an error.
- AUTO_START, 1: 1 = begin the sequence after reset release; 0 = wait for cfg_start.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- cfg_start  in  1  one-cycle pulse; starts or restarts the sequence from IDLE, DONE or ERROR
- lut_index  out  10  table address
- lut_data  in  32  table entry (combinational from lut_index)
- i2c_req  out  1  write request, held until i2c_done
- i2c_dev_addr  out  8  8-bit device address
- i2c_reg_addr  out  16  register address
- i2c_wr_data  out  8  register data
- i2c_done  in  1  one-cycle completion pulse
- i2c_nack  in  1  qualifies i2c_done; 1 = transfer failed
- cfg_busy  out  1  sequence in progress
- cfg_done  out  1  sticky; set at sentinel
- cfg_error  out  1  sticky; retries exhausted or table overrun

Behaviour:
- Reset values: all outputs 0, lut_index 0, state IDLE. Reset mid-sequence aborts immediately; i2c_req drops asynchronously.
- States: IDLE, PWR_WAIT, FETCH, REQ, SETTLE, GAP, DONE, ERROR.
- IDLE:
  - If AUTO_START=1, move to PWR_WAIT on the first clock after reset release.
  - Otherwise move to PWR_WAIT on cfg_start.
  - Entry to PWR_WAIT clears lut_index, cfg_done, cfg_error and the retry count.
- PWR_WAIT: count PWR_UP_CYCLES, then go to FETCH.
- FETCH: one cycle. lut_data is sampled at the end of the cycle in which lut_index is stable; lut_index changes only on the FETCH exit cycle. Decode:
  - dev_addr==8'hFF: sentinel → DONE.
  - dev_addr==8'h00: table hole; lut_index+1, stay in FETCH (one cycle per hole).
  - Otherwise: register the three fields onto the i2c_* outputs → REQ.
- REQ:
  - i2c_req=1 with fields stable until i2c_done.
  - i2c_done with i2c_nack=0: clear retry count. If lut_index==0 go to SETTLE, else go to GAP.
  - i2c_done with i2c_nack=1: if retry count < MAX_RETRY, increment it and go to GAP, then re-issue the same index. Otherwise go to ERROR.
  - i2c_req deasserts in the cycle after i2c_done; there is no back-to-back request.
- SETTLE: count SETTLE_CYCLES, then GAP.
- GAP:
  - Count GAP_CYCLES, then go to FETCH.
  - lut_index increments at GAP exit only for a successful write; a retry keeps the index.
  - If the index about to be fetched would exceed LUT_DEPTH, go to ERROR instead.
- DONE / ERROR: cfg_done or cfg_error set; cfg_busy=0; hold until cfg_start.
- cfg_busy=1 in PWR_WAIT through GAP.
- cfg_start while busy is ignored.
- Duplicate table indices are the table's concern. The sequencer issues exactly what is returned per index.
- Counters saturate and never wrap. lut_index never exceeds LUT_DEPTH.

Optional Feature:
- Macro: OV5640_CFG_READBACK_EN.
- When defined:
  - Adds ports i2c_rd (out 1), i2c_rd_data (in 8) and mismatch_cnt (out 8, reset 0, saturating).
  - After each successful write, a READ state issues the same address with i2c_rd=1, using the same handshake.
  - If i2c_rd_data != i2c_wr_data, mismatch_cnt increments.
  - Readback is skipped at index 0.
  - A NACK on readback counts as a mismatch and does not retry.
- When undefined: no READ state and no extra ports.

Decomposition:
- Shared package ov5640_cfg_pkg holds:
  - the state enum;
  - the sentinel constant 8'hFF and the hole constant 8'h00;
  - the field slice positions.
- Sub-module cfg_delay_cnt: a loadable down-counter with a zero flag, reused for PWR_WAIT, SETTLE and GAP.

Test Plan:
- AUTO_START=1, PWR_UP_CYCLES=10, three entries then sentinel at index 3, ideal slave → exactly 3 requests carrying 0x78/0x3008/0x02 etc.; cfg_done=1; lut_index=3; first i2c_req no earlier than cycle 11.
- Table hole at indices 5–6 (dev 0x00) → no request issued for 5 or 6; next request carries index 7 data; FETCH dwell is 3 cycles.
- NACK on index 2, twice, then ACK, MAX_RETRY=3 → three requests with identical fields, then continue; cfg_error=0.
- NACK 4 times on index 2 → cfg_error=1, cfg_busy=0, i2c_req=0; cfg_start then restarts from index 0.
- rst_n asserted while i2c_req=1 → i2c_req=0 asynchronously; all outputs return to reset values; sequence reruns after release.
- No sentinel, LUT_DEPTH=8 → ERROR after the write at index 8; lut_index stays 8.
